// File: rtl/axis_capture_mem.sv
// axis_capture_mem: multi-channel AXI-Stream capture buffers with level-relative reads.
// Optional per-channel overflow counters are built when AXIS_CAPTURE_OVF_CNT_EN is defined.
module axis_capture_mem #(
  parameter string MEMORY_TYPE = "distributed",
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CHANNELS = 4,
  parameter int ONE_SHOT = 0,
  localparam int AW = $clog2(MEMORY_DEPTH),
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1,
  localparam int LW = AW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [CW-1:0]           s_axis_tdest,
  input  logic                    s_axis_tlast,
  input  logic [NUM_CHANNELS-1:0] clr,
  input  logic [CW-1:0]           rd_chan,
  input  logic [AW-1:0]           rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic [LW-1:0]           level,
  output logic [NUM_CHANNELS-1:0] frame_done,
  output logic [15:0]             ovf_count
);
  localparam logic [LW-1:0] FULL = LW'(MEMORY_DEPTH);
  logic [AW-1:0] wr_ptr [NUM_CHANNELS];
  logic [LW-1:0] lvl [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] done;
  logic [AW-1:0] w_ptr, r_ptr, r_off;
  logic [LW-1:0] w_lvl, r_lvl;
  logic w_hit, w_done, w_clr, accept, wr_en, rd_ok, rd_ok_q;
  logic [CW+AW-1:0] wr_addr, rd_full;
  logic [DATA_WIDTH-1:0] rd_raw;
  always_comb begin
    w_ptr = '0;
    w_lvl = '0;
    w_hit = 1'b0;
    w_done = 1'b0;
    w_clr = 1'b0;
    r_ptr = '0;
    r_lvl = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (int'(s_axis_tdest) == i) begin
        w_hit = 1'b1;
        w_ptr = wr_ptr[i];
        w_lvl = lvl[i];
        w_done = done[i];
        w_clr = clr[i];
      end
      if (int'(rd_chan) == i) begin
        r_ptr = wr_ptr[i];
        r_lvl = lvl[i];
      end
    end
  end
  assign s_axis_tready = !(ONE_SHOT != 0 && w_hit && w_lvl == FULL && !w_done);
  assign accept = s_axis_tvalid && s_axis_tready;
  assign wr_en = accept && w_hit && !w_clr;
  // a closed frame restarts at location 0
  assign wr_addr = {s_axis_tdest, w_done ? AW'(0) : w_ptr};
  assign r_off = r_ptr - r_lvl[AW-1:0] + rd_addr;
  assign rd_full = {rd_chan, r_off};
  assign rd_ok = {1'b0, rd_addr} < r_lvl;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        wr_ptr[i] <= '0;
        lvl[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (clr[i]) begin
          wr_ptr[i] <= '0;
          lvl[i] <= '0;
          done[i] <= 1'b0;
        end else if (accept && int'(s_axis_tdest) == i) begin
          wr_ptr[i] <= done[i] ? AW'(1) : wr_ptr[i] + 1'b1;
          lvl[i] <= done[i] ? LW'(1) : (lvl[i] == FULL ? FULL : lvl[i] + 1'b1);
          done[i] <= s_axis_tlast;
        end
      end
    end
  end
  assign frame_done = done;
  // nonblocking write plus registered read gives read-first behaviour
  if (MEMORY_TYPE == "block") begin : g_bram
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [2**(CW+AW)];
    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= s_axis_tdata;
      rd_raw <= mem[rd_full];
    end
  end else begin : g_dram
    (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [2**(CW+AW)];
    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= s_axis_tdata;
      rd_raw <= mem[rd_full];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ok_q <= 1'b0;
      level <= '0;
    end else begin
      rd_ok_q <= rd_ok;
      level <= r_lvl;
    end
  end
  assign rd_valid = rd_ok_q;
  assign rd_data = rd_ok_q ? rd_raw : '0;
`ifdef AXIS_CAPTURE_OVF_CNT_EN
  logic [15:0] ovf [NUM_CHANNELS];
  logic [15:0] r_ovf, ovf_q;
  always_comb begin
    r_ovf = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) r_ovf = int'(rd_chan) == i ? ovf[i] : r_ovf;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) ovf[i] <= '0;
    end else begin
      ovf_q <= r_ovf;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (clr[i] || (accept && int'(s_axis_tdest) == i && done[i]))
          ovf[i] <= '0;
        else if (ovf[i] != 16'hFFFF && int'(s_axis_tdest) == i &&
                 (ONE_SHOT != 0 ? s_axis_tvalid && !s_axis_tready : accept && lvl[i] == FULL && !done[i]))
          ovf[i] <= ovf[i] + 1'b1;
      end
    end
  end
  assign ovf_count = ovf_q;
`else
  assign ovf_count = '0;
`endif
endmodule

// File: tb/tb_axis_capture_mem.sv
// tb_axis_capture_mem: scoreboard bench for a circular and a one-shot capture buffer.
module tb_axis_capture_mem;
`ifdef AXIS_CAPTURE_OVF_CNT_EN
  localparam bit OV = 1;
`else
  localparam bit OV = 0;
`endif
  typedef struct {
    bit d;
    logic v;
    logic [31:0] data;
    logic [5:0] lvl;
    logic [15:0] ovf;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, acc;
  logic clk = 0, rst_n = 0, rd_req = 0;
  logic [1:0] rd_chan = '0;
  logic [4:0] rd_addr = '0;
  logic v0 = 0, r0, l0 = 0, rv0, v1 = 0, r1, l1 = 0, rv1;
  logic [31:0] d0 = '0, d1 = '0, rdd0, rdd1;
  logic [1:0] t0 = '0, t1 = '0;
  logic [3:0] c0 = '0, c1 = '0, fd0, fd1;
  logic [5:0] lv0, lv1;
  logic [15:0] oc0, oc1;
  always #5 clk = ~clk;
  axis_capture_mem dut0 (
    .clk(clk), .rst_n(rst_n), .s_axis_tvalid(v0), .s_axis_tready(r0), .s_axis_tdata(d0),
    .s_axis_tdest(t0), .s_axis_tlast(l0), .clr(c0), .rd_chan(rd_chan), .rd_addr(rd_addr),
    .rd_data(rdd0), .rd_valid(rv0), .level(lv0), .frame_done(fd0), .ovf_count(oc0)
  );
  axis_capture_mem #(.ONE_SHOT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_axis_tvalid(v1), .s_axis_tready(r1), .s_axis_tdata(d1),
    .s_axis_tdest(t1), .s_axis_tlast(l1), .clr(c1), .rd_chan(rd_chan), .rd_addr(rd_addr),
    .rd_data(rdd1), .rd_valid(rv1), .level(lv1), .frame_done(fd1), .ovf_count(oc1)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic beat(input bit dut, input logic [1:0] dest, input logic [31:0] data, input bit last);
    @(negedge clk);
    if (dut) begin v1 = 1; t1 = dest; d1 = data; l1 = last; end
    else begin v0 = 1; t0 = dest; d0 = data; l0 = last; end
  endtask
  task automatic idle();
    @(negedge clk);
    v0 = 0; v1 = 0; l0 = 0; l1 = 0; c0 = '0; c1 = '0;
  endtask
  task automatic rd(input bit dut, input logic [1:0] ch, input logic [4:0] addr, input logic ev,
                    input logic [31:0] ed, input logic [5:0] el, input logic [15:0] eo);
    @(negedge clk);
    rd_req = 1; rd_chan = ch; rd_addr = addr;
    sb.push_back('{dut, ev, ed, el, eo});
  endtask
  task automatic rd_end();
    @(negedge clk);
    rd_req = 0;
  endtask
  always @(posedge clk) begin : mon
    exp_t e;
    if (rd_req) begin
      #1;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("rd_valid", e.d ? rv1 : rv0, e.v);
        chk("rd_data", e.d ? rdd1 : rdd0, e.data);
        chk("level", e.d ? lv1 : lv0, e.lvl);
        chk("ovf_count", e.d ? oc1 : oc0, e.ovf);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rd_data", rdd0, 0);
    chk("rst_rd_valid", rv0, 0);
    chk("rst_level", lv0, 0);
    chk("rst_fd", fd0, 0);
    chk("rst_ovf", oc0, 0);
    chk("rst_tready", r0, 1);
    rst_n = 1;
    for (int i = 0; i < 5; i++) beat(0, 2, 32'hA0 + i, 0);
    idle();
    for (int i = 0; i < 6; i++) rd(0, 2, i, i < 5, i < 5 ? 32'hA0 + i : 0, 5, 0);
    rd_end();
    for (int i = 0; i < 40; i++) beat(0, 0, i, 0);
    idle();
    rd(0, 0, 0, 1, 8, 32, OV ? 8 : 0);
    rd(0, 0, 31, 1, 39, 32, OV ? 8 : 0);
    rd(0, 2, 0, 1, 32'hA0, 5, 0);
    rd_end();
    for (int i = 1; i <= 3; i++) beat(0, 3, i, i == 3);
    idle();
    chk("frame_done_set", fd0, 4'b1000);
    rd(0, 3, 2, 1, 3, 3, 0);
    rd_end();
    beat(0, 3, 32'h55, 0);
    idle();
    chk("frame_done_clr", fd0, 0);
    rd(0, 3, 0, 1, 32'h55, 1, 0);
    rd(0, 3, 1, 0, 0, 1, 0);
    rd_end();
    acc = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      v1 = 1; t1 = 1; d1 = i;
      #1 if (r1) acc++;
    end
    @(negedge clk);
    v1 = 0;
    #1 chk("os_full_rdy", r1, 0);
    chk("os_accepted", acc, 32);
    t1 = 0;
    #1 chk("os_ch0_rdy", r1, 1);
    rd(1, 1, 0, 1, 0, 32, OV ? 3 : 0);
    rd(1, 1, 31, 1, 31, 32, OV ? 3 : 0);
    rd_end();
    beat(1, 0, 32'hC0, 0);
    idle();
    rd(1, 0, 0, 1, 32'hC0, 1, 0);
    rd_end();
    @(negedge clk);
    c0 = 4'b0001; v0 = 1; t0 = 0; d0 = 32'h77;
    idle();
    rd(0, 0, 0, 0, 0, 0, 0);
    rd(0, 2, 4, 1, 32'hA4, 5, 0);
    rd_end();
    beat(0, 0, 32'h88, 0);
    idle();
    rd(0, 0, 0, 1, 32'h88, 1, 0);
    rd_end();
    beat(0, 3, 32'h99, 1);
    beat(0, 1, 32'h11, 0);
    @(negedge clk);
    rd_chan = 2; rd_addr = 0; d0 = 32'h12;
    @(posedge clk);
    #2 chk("pre_rst_valid", rv0, 1);
    chk("pre_rst_data", rdd0, 32'hA0);
    chk("pre_rst_fd", fd0[3], 1);
    rst_n = 0;
    #1 chk("async_rd_data", rdd0, 0);
    chk("async_rd_valid", rv0, 0);
    chk("async_level", lv0, 0);
    chk("async_fd", fd0, 0);
    chk("async_ovf", oc0, 0);
    chk("async_level1", lv1, 0);
    v0 = 0;
    @(negedge clk);
    rst_n = 1;
    rd(0, 2, 0, 0, 0, 0, 0);
    rd_end();
    repeat (2) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_capture_mem.md
AXIS_CAPTURE_MEM -- requirements
Module: axis_capture_mem

Interface
REQ-001 SHALL have parameter MEMORY_TYPE, default "distributed", the RAM primitive passed to the memory macro ("distributed" or "block").
REQ-002 SHALL have parameter MEMORY_DEPTH, default 32, beats per channel; legal values are powers of two, 2..4096.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, the beat width.
REQ-004 SHALL have parameter NUM_CHANNELS, default 4, independent capture buffers; legal range 1..16.
REQ-005 SHALL have parameter ONE_SHOT, default 0: 0 = circular overwrite, 1 = stop when full.
REQ-006 SHALL derive AW = log2(MEMORY_DEPTH), CW = max(1, log2(NUM_CHANNELS)) and LW = AW+1.
REQ-007 Ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat ready.
- s_axis_tdata  in  DATA_WIDTH  beat data.
- s_axis_tdest  in  CW  target channel.
- s_axis_tlast  in  1  last beat of frame.
- clr  in  NUM_CHANNELS  per-channel synchronous clear pulse.
- rd_chan  in  CW  read channel.
- rd_addr  in  AW  read offset; 0 = oldest stored beat.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  registered: offset held data.
- level  out  LW  registered fill level of rd_chan.
- frame_done  out  NUM_CHANNELS  sticky per-channel frame-complete flag.
- ovf_count  out  16  overflow count of rd_chan.

Function
REQ-008 A beat SHALL be accepted when s_axis_tvalid and s_axis_tready are both high; tdest >= NUM_CHANNELS SHALL be accepted and discarded.
REQ-009 With ONE_SHOT=0, s_axis_tready SHALL be constantly 1 out of reset.
REQ-010 With ONE_SHOT=1, s_axis_tready SHALL be 0 while the tdest channel's level equals MEMORY_DEPTH and its frame is not closed; otherwise it SHALL be 1.
- The ready decision is combinational from tdest and registered state.
REQ-011 Each accepted beat SHALL be written to the storage location {tdest, wr_ptr}; wr_ptr then increments mod MEMORY_DEPTH and level saturates at MEMORY_DEPTH.
REQ-012 With ONE_SHOT=0, a write at level==MEMORY_DEPTH SHALL overwrite the oldest beat (wrap-around).
REQ-013 An accepted beat with tlast high SHALL be stored and SHALL close the channel's frame; frame_done[ch] SHALL be set on the following cycle.
REQ-014 The next accepted beat to a closed channel SHALL start a new frame: it is written at pointer 0, level becomes 1, and frame_done[ch] clears.
REQ-015 A read request (rd_chan, rd_addr) in cycle N SHALL produce rd_data, rd_valid and level in cycle N+1 (latency 1).
REQ-016 The read address SHALL be the physical location (wr_ptr - level + rd_addr) mod MEMORY_DEPTH, using the state sampled in cycle N.
REQ-017 rd_valid SHALL be 1 only if rd_addr < level; when it is 0, rd_data SHALL be all zeros.
REQ-018 A read and a write to the same location in one cycle SHALL return the pre-write data (read-first).
REQ-019 clr[ch] SHALL zero that channel's wr_ptr, level, frame_done and overflow count on the next edge.
- A beat to the same channel in the same cycle SHALL be accepted and discarded (clear wins).
REQ-020 Channels SHALL be fully independent; a write or clear to one channel SHALL NOT alter another channel's state.

Reset
REQ-021 Asserting rst_n low SHALL asynchronously force, for all channels, wr_ptr=0, level=0, frame_done=0, rd_data=0, rd_valid=0, level output=0 and ovf_count=0.
REQ-022 Memory contents need not be reset; the level-based rd_valid gating SHALL hide stale data.
REQ-023 Reset deassertion SHALL be synchronised externally; the block accepts beats on the first edge after release.

Configuration
REQ-024 With macro AXIS_CAPTURE_OVF_CNT_EN defined, each channel SHALL keep a saturating 16-bit counter.
- ONE_SHOT=0: counts accepted beats written while level==MEMORY_DEPTH.
- ONE_SHOT=1: counts cycles with tvalid high and tready low for that channel.
- The counter is cleared by reset, clr or frame restart; ovf_count reports rd_chan with latency 1.
REQ-025 Without AXIS_CAPTURE_OVF_CNT_EN, no counter logic SHALL exist and ovf_count SHALL be tied to 0.

Verification
REQ-026 Defaults; write 5 beats 0xA0..0xA4 to ch2, read offsets 0..5 -> rd_data 0xA0..0xA4 with rd_valid=1, offset 5 gives rd_valid=0 and rd_data=0, level=5.
REQ-027 ONE_SHOT=0, depth 32; write 40 beats 0..39 to ch0 -> offset 0 reads 8, offset 31 reads 39, level=32, ovf_count=8 (macro defined).
REQ-028 ONE_SHOT=1; hold tvalid for 35 cycles to ch1 -> tready drops after beat 32, level=32, ovf_count=3, ch0 still accepts.
REQ-029 Write 3 beats to ch3 with tlast on the third, then beat 0x55 -> frame_done[3] pulses high then clears, level=1, offset 0 reads 0x55.
REQ-030 Pulse clr[0] together with a beat to ch0 mid-frame, then assert rst_n low mid-stream -> after clr: level 0, beat discarded; after reset: all outputs 0 asynchronously.
